// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: per-pin two-flop synchronizer, debounce filter and
// sticky edge-capture flags with a combined interrupt output.
module gpio_input_conditioner #(
    parameter int unsigned IO_COUNT    = 16,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IO_COUNT-1:0]    pad_input,
    input  logic [COUNT_WIDTH-1:0] debounce_period,
    input  logic [IO_COUNT-1:0]    rise_enable,
    input  logic [IO_COUNT-1:0]    fall_enable,
    input  logic                   clear_strobe,
    input  logic [IO_COUNT-1:0]    clear_mask,
    output logic [IO_COUNT-1:0]    gpio_input,
    output logic [IO_COUNT-1:0]    edge_pending,
    output logic                   edge_irq
);

    logic [IO_COUNT-1:0]    sync1_q;
    logic [IO_COUNT-1:0]    sync2_q;
    logic [IO_COUNT-1:0]    stable_q;
    logic [IO_COUNT-1:0]    stable_d;
    logic [IO_COUNT-1:0]    pend_q;
    logic [IO_COUNT-1:0]    pend_d;
    logic [IO_COUNT-1:0]    pend_set;
    logic [IO_COUNT-1:0]    pend_clr;
    logic [COUNT_WIDTH-1:0] cnt_q [IO_COUNT];
    logic [COUNT_WIDTH-1:0] cnt_d [IO_COUNT];

    // Debounce decision per pin and next value of the sticky pending flags.
    always_comb begin
        stable_d = stable_q;
        pend_set = '0;
        for (int unsigned i = 0; i < IO_COUNT; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] >= debounce_period) begin
                    // Update event: accept the new level and flag it if enabled.
                    stable_d[i] = sync2_q[i];
                    pend_set[i] = sync2_q[i] ? rise_enable[i] : fall_enable[i];
                end else if (cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
            end
        end
        pend_clr = clear_strobe ? clear_mask : '0;
        // A set on the same edge as a clear wins.
        pend_d   = (pend_q & ~pend_clr) | pend_set;
    end

    // Synchronizer, debounced level, counters and pending flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            pend_q   <= '0;
            for (int unsigned i = 0; i < IO_COUNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= pad_input;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pend_q   <= pend_d;
            for (int unsigned i = 0; i < IO_COUNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gpio_input   = stable_q;
    assign edge_pending = pend_q;
    assign edge_irq     = |pend_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Self-checking bench for gpio_input_conditioner: directed scenarios with
// fixed expectations plus a randomized run against a cycle-level model.
module tb_gpio_input_conditioner;

    localparam int IO = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [IO-1:0] pad;
    logic [CW-1:0] period;
    logic [IO-1:0] rise_en;
    logic [IO-1:0] fall_en;
    logic          clr;
    logic [IO-1:0] clr_mask;
    logic [IO-1:0] gpio;
    logic [IO-1:0] pend;
    logic          irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pad delayed two samples, then a run-length debounce.
    logic [IO-1:0] m_s1, m_s2, m_stable, m_pend;
    int            m_run [IO];

    always #5 clk = ~clk;

    gpio_input_conditioner #(
        .IO_COUNT    (IO),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pad_input       (pad),
        .debounce_period (period),
        .rise_enable     (rise_en),
        .fall_enable     (fall_en),
        .clear_strobe    (clr),
        .clear_mask      (clr_mask),
        .gpio_input      (gpio),
        .edge_pending    (pend),
        .edge_irq        (irq)
    );

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0;
        for (int i = 0; i < IO; i++) m_run[i] = 0;
    endtask

    task automatic model_edge();
        logic [IO-1:0] setv;
        logic [IO-1:0] nstable;
        setv    = '0;
        nstable = m_stable;
        for (int i = 0; i < IO; i++) begin
            if (m_s2[i] !== m_stable[i]) begin
                if (m_run[i] >= int'(period)) begin
                    nstable[i] = m_s2[i];
                    setv[i]    = m_s2[i] ? rise_en[i] : fall_en[i];
                    m_run[i]   = 0;
                end else begin
                    m_run[i] = (m_run[i] + 1 > 255) ? 255 : m_run[i] + 1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_pend   = (m_pend & ~(clr ? clr_mask : '0)) | setv;
        m_stable = nstable;
        m_s2     = m_s1;
        m_s1     = pad;
    endtask

    // One rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; pad = '0; period = '0; rise_en = '0; fall_en = '0;
        clr = 1'b0; clr_mask = '0;
        model_reset();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; pad = '1; period = '0; rise_en = '1; fall_en = '1;
        clr = 1'b0; clr_mask = '0;
        model_reset();
        #1;
        n_tests++;
        if (gpio !== '0 || pend !== '0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: gpio=%h pend=%h irq=%b required all 0", gpio, pend, irq);
        end
        for (int e = 0; e < 4; e++) step();
        n_tests++;
        if (gpio !== '0 || pend !== '0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: gpio=%h pend=%h irq=%b required all 0", gpio, pend, irq);
        end
    endtask

    task automatic test_rise_period0();
        do_reset();
        rise_en = 16'h0008;
        pad     = 16'h0008;
        for (int e = 1; e <= 3; e++) begin
            logic exp;
            step();
            exp = (e == 3);
            n_tests++;
            if (gpio[3] !== exp || pend[3] !== exp || irq !== exp) begin
                n_fail++;
                $display("FAIL rise_p0 edge %0d: gpio3=%b pend3=%b irq=%b required %b",
                         e, gpio[3], pend[3], irq, exp);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        period = 8'd4;
        pad    = 16'h0001;
        for (int e = 0; e < 3; e++) step();
        pad = 16'h0000;
        for (int e = 0; e < 6; e++) step();
        n_tests++;
        if (gpio[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_filtered: gpio0=%b required 0", gpio[0]);
        end
        pad = 16'h0001;
        for (int e = 1; e <= 7; e++) begin
            step();
            n_tests++;
            if (gpio[0] !== (e == 7)) begin
                n_fail++;
                $display("FAIL debounce_p4 edge %0d: gpio0=%b required %b", e, gpio[0], e == 7);
            end
        end
    endtask

    task automatic test_fall_only();
        do_reset();
        fall_en = 16'h0020;
        pad     = 16'h0020;
        for (int e = 0; e < 3; e++) step();
        n_tests++;
        if (gpio[5] !== 1'b1 || pend !== 16'h0000) begin
            n_fail++;
            $display("FAIL fall_only_rise: gpio5=%b pend=%h required 1 / 0000", gpio[5], pend);
        end
        pad = 16'h0000;
        for (int e = 0; e < 3; e++) step();
        n_tests++;
        if (gpio[5] !== 1'b0 || pend !== 16'h0020 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL fall_only_fall: gpio5=%b pend=%h irq=%b required 0 / 0020 / 1",
                     gpio[5], pend, irq);
        end
    endtask

    task automatic test_clear();
        do_reset();
        rise_en = 16'h0003;
        pad     = 16'h0003;
        for (int e = 0; e < 3; e++) step();
        n_tests++;
        if (pend !== 16'h0003) begin
            n_fail++;
            $display("FAIL clear_setup: pend=%h required 0003", pend);
        end
        rise_en  = '0;
        clr      = 1'b1;
        clr_mask = 16'h0001;
        step();
        clr = 1'b0;
        n_tests++;
        if (pend !== 16'h0002 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_bit0: pend=%h irq=%b required 0002 / 1", pend, irq);
        end
        clr      = 1'b1;
        clr_mask = 16'h0002;
        step();
        clr = 1'b0;
        n_tests++;
        if (pend !== 16'h0000 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_bit1: pend=%h irq=%b required 0000 / 0", pend, irq);
        end
    endtask

    task automatic test_set_clear_collide();
        do_reset();
        rise_en = 16'h0004;
        pad     = 16'h0004;
        step();
        step();
        clr      = 1'b1;
        clr_mask = 16'h0004;
        step();
        clr = 1'b0;
        n_tests++;
        if (pend[2] !== 1'b1 || gpio[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL set_beats_clear: pend2=%b gpio2=%b required 1 / 1", pend[2], gpio[2]);
        end
    endtask

    task automatic test_reset_midcount();
        do_reset();
        rise_en = '1;
        pad     = '1;
        for (int e = 0; e < 3; e++) step();
        period = 8'd200;
        pad    = '0;
        for (int e = 0; e < 50; e++) step();
        n_tests++;
        if (gpio !== '1 || pend !== '1) begin
            n_fail++;
            $display("FAIL midcount_setup: gpio=%h pend=%h required ffff / ffff", gpio, pend);
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (gpio !== '0 || pend !== '0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: gpio=%h pend=%h irq=%b required all 0", gpio, pend, irq);
        end
        pad = '1;
        step();
        rst = 1'b1;
        for (int e = 1; e <= 203; e++) begin
            step();
            if (e == 202) begin
                n_tests++;
                if (gpio !== '0 || pend !== '0) begin
                    n_fail++;
                    $display("FAIL p200_edge202: gpio=%h pend=%h required 0000 / 0000", gpio, pend);
                end
            end
        end
        n_tests++;
        if (gpio !== '1 || pend !== '1 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL p200_edge203: gpio=%h pend=%h irq=%b required ffff / ffff / 1",
                     gpio, pend, irq);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        period  = 8'($urandom_range(0, 5));
        rise_en = 16'($urandom);
        fall_en = 16'($urandom);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < IO; i++) begin
                if ($urandom_range(0, 4) == 0) pad[i] = ~pad[i];
            end
            if ($urandom_range(0, 40) == 0) period = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 60) == 0) begin
                rise_en = 16'($urandom);
                fall_en = 16'($urandom);
            end
            clr      = ($urandom_range(0, 7) == 0);
            clr_mask = 16'($urandom);
            step();
            n_tests++;
            if (gpio !== m_stable || pend !== m_pend || irq !== (|m_pend)) begin
                n_fail++;
                if (bad < 10) begin
                    $display("FAIL random cycle %0d: gpio=%h pend=%h irq=%b required %h / %h / %b",
                             c, gpio, pend, irq, m_stable, m_pend, |m_pend);
                end
                bad++;
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rise_period0();
        test_glitch();
        test_fall_only();
        test_clear();
        test_set_clear_collide();
        test_reset_midcount();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
